// File: rtl/signed_max_scan_pkg.sv
// Shared definitions for the signed max/min scan unit.
//   state_t        : controller states (idle, scanning, result held)
//   SMIN / SMAX    : most negative / most positive 32-bit two's-complement values
//   DEF_DATA_W     : default operand width
package signed_max_scan_pkg;

  localparam int unsigned DEF_DATA_W = 32;

  localparam logic [DEF_DATA_W-1:0] SMIN = 32'h8000_0000;
  localparam logic [DEF_DATA_W-1:0] SMAX = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } state_t;

endpackage

// File: rtl/signed_cmp.sv
// Combinational two's-complement comparator.
//   i_a, i_b : operands (signed)
//   o_gt     : a > b
//   o_lt     : a < b
module signed_cmp #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_gt,
  output logic         o_lt
);

  assign o_gt = $signed(i_a) > $signed(i_b);
  assign o_lt = $signed(i_a) < $signed(i_b);

endmodule

// File: rtl/signed_max_scan.sv
// Multi-cycle signed max/min reduction controller.
// A start command latches a length; that many words are then taken over a valid/ready input while
// the running maximum, minimum and index of the first maximum are tracked. The result is offered
// over a valid/ready output. busy flags the unit as occupied for the pipeline stall logic.
//   clk, reset            : clock, synchronous active-high reset
//   start, len            : command strobe and word count (honoured only when idle)
//   in_valid/in_ready     : input word handshake, in_data is the signed word
//   out_valid/out_ready   : result handshake
//   max_val, min_val      : running/final signed maximum and minimum
//   max_idx               : 0-based index of the first occurrence of the maximum
//   empty                 : result came from a zero-length command
//   busy                  : high while scanning or holding a result
module signed_max_scan
  import signed_max_scan_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] min_val,
  output logic [LEN_W-1:0]  max_idx,
  output logic              empty
);

  state_t              r_state_q, r_state_d;
  logic [LEN_W-1:0]    r_len_q, r_len_d;
  logic [LEN_W-1:0]    r_cnt_q, r_cnt_d;
  logic [DATA_W-1:0]   r_max_q, r_max_d;
  logic [DATA_W-1:0]   r_min_q, r_min_d;
  logic [LEN_W-1:0]    r_idx_q, r_idx_d;
  logic                r_empty_q, r_empty_d;

  logic w_gt_max;
  logic w_lt_min;
  logic w_unused_gt_min;
  logic w_unused_lt_max;
  logic w_last;

  signed_cmp #(
    .W (DATA_W)
  ) u_cmp_max (
    .i_a  (in_data),
    .i_b  (r_max_q),
    .o_gt (w_gt_max),
    .o_lt (w_unused_lt_max)
  );

  signed_cmp #(
    .W (DATA_W)
  ) u_cmp_min (
    .i_a  (in_data),
    .i_b  (r_min_q),
    .o_gt (w_unused_gt_min),
    .o_lt (w_lt_min)
  );

  // len is never zero while scanning, so len-1 cannot wrap here.
  assign w_last = (r_cnt_q == (r_len_q - LEN_W'(1)));

  always_comb begin
    r_state_d = r_state_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_max_d   = r_max_q;
    r_min_d   = r_min_q;
    r_idx_d   = r_idx_q;
    r_empty_d = r_empty_q;

    unique case (r_state_q)
      StIdle: begin
        if (start) begin
          r_len_d = len;
          r_cnt_d = '0;
          r_max_d = SMIN;
          r_min_d = SMAX;
          r_idx_d = '0;
          if (len == '0) begin
            r_empty_d = 1'b1;
            r_state_d = StDone;
          end else begin
            r_empty_d = 1'b0;
            r_state_d = StScan;
          end
        end
      end
      StScan: begin
        if (in_valid) begin
          // Strict compares keep the earliest index on ties.
          if (w_gt_max) begin
            r_max_d = in_data;
            r_idx_d = r_cnt_q;
          end
          if (w_lt_min) begin
            r_min_d = in_data;
          end
          r_cnt_d = r_cnt_q + LEN_W'(1);
          if (w_last) begin
            r_state_d = StDone;
          end
        end
      end
      StDone: begin
        // start is deliberately ignored here, even alongside out_ready.
        if (out_ready) begin
          r_state_d = StIdle;
        end
      end
      default: r_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= StIdle;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_max_q   <= '0;
      r_min_q   <= '0;
      r_idx_q   <= '0;
      r_empty_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_max_q   <= r_max_d;
      r_min_q   <= r_min_d;
      r_idx_q   <= r_idx_d;
      r_empty_q <= r_empty_d;
    end
  end

  assign in_ready  = (r_state_q == StScan);
  assign out_valid = (r_state_q == StDone);
  assign busy      = (r_state_q == StScan) || (r_state_q == StDone);
  assign max_val   = r_max_q;
  assign min_val   = r_min_q;
  assign max_idx   = r_idx_q;
  assign empty     = r_empty_q;

endmodule

// File: tb/tb_signed_max_scan.sv
// Directed self-checking bench for signed_max_scan.
// Inputs change and outputs are sampled on the falling edge; the DUT samples on the rising edge.
module tb_signed_max_scan;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] max_val;
  logic [31:0] min_val;
  logic [7:0]  max_idx;
  logic        empty;

  int n_pass;
  int n_total;

  signed_max_scan #(
    .DATA_W (32),
    .LEN_W  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .max_val   (max_val),
    .min_val   (min_val),
    .max_idx   (max_idx),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Issue start for one rising edge; returns in the first cycle after it.
  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = 8'hAA;  // later len changes must not matter
  endtask

  // Present one word for one rising edge with in_valid high.
  task automatic send_beat(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_total++;
    if ({in_ready, busy, out_valid, empty} !== 4'b0000)
      $display("FAIL reset_hs: got %b expected 0000", {in_ready, busy, out_valid, empty});
    else n_pass++;
    n_total++;
    if ({max_val, min_val, max_idx} !== 72'h0)
      $display("FAIL reset_data: got max=%h min=%h idx=%0d expected all 0",
               max_val, min_val, max_idx);
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic ov_before;
    do_start(8'd4);
    n_total++;
    if ({in_ready, busy, out_valid} !== 3'b110)
      $display("FAIL basic_scan_entry: got %b expected 110", {in_ready, busy, out_valid});
    else n_pass++;
    send_beat(32'd5);
    n_total++;
    if (max_val !== 32'd5 || min_val !== 32'd5 || max_idx !== 8'd0)
      $display("FAIL basic_running: got max=%h min=%h idx=%0d expected 5 5 0",
               max_val, min_val, max_idx);
    else n_pass++;
    send_beat(32'hFFFF_FFFD);
    send_beat(32'h7FFF_FFFF);
    ov_before = out_valid;
    send_beat(32'd2);
    n_total++;
    if (ov_before !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL basic_latency: got ov_prev=%b ov=%b rdy=%b expected 0 1 0",
               ov_before, out_valid, in_ready);
    else n_pass++;
    n_total++;
    if (max_val !== 32'h7FFF_FFFF || max_idx !== 8'd2 || min_val !== 32'hFFFF_FFFD ||
        empty !== 1'b0)
      $display("FAIL basic_result: got max=%h idx=%0d min=%h empty=%b expected 7fffffff 2 fffffffd 0",
               max_val, max_idx, min_val, empty);
    else n_pass++;
    release_result();
    n_total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || max_val !== 32'h7FFF_FFFF)
      $display("FAIL basic_idle_hold: got busy=%b ov=%b max=%h expected 0 0 7fffffff",
               busy, out_valid, max_val);
    else n_pass++;
  endtask

  task automatic test_all_min();
    do_start(8'd3);
    for (int i = 0; i < 3; i++) send_beat(32'h8000_0000);
    n_total++;
    if (out_valid !== 1'b1 || max_val !== 32'h8000_0000 || max_idx !== 8'd0 ||
        min_val !== 32'h8000_0000)
      $display("FAIL all_min: got ov=%b max=%h idx=%0d min=%h expected 1 80000000 0 80000000",
               out_valid, max_val, max_idx, min_val);
    else n_pass++;
    release_result();
  endtask

  task automatic test_stalls();
    logic [31:0] w [3];
    w[0] = 32'd7;
    w[1] = 32'd7;
    w[2] = 32'hFFFF_FFFF;
    do_start(8'd3);
    for (int b = 0; b < 3; b++) begin
      if (b != 0) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          n_total++;
          if (busy !== 1'b1 || in_ready !== 1'b1 || max_val !== 32'd7 || max_idx !== 8'd0)
            $display("FAIL stall_gap: got busy=%b rdy=%b max=%h idx=%0d expected 1 1 7 0",
                     busy, in_ready, max_val, max_idx);
          else n_pass++;
        end
      end
      send_beat(w[b]);
    end
    n_total++;
    if (out_valid !== 1'b1 || max_val !== 32'd7 || max_idx !== 8'd0 || min_val !== 32'hFFFF_FFFF)
      $display("FAIL stall_result: got ov=%b max=%h idx=%0d min=%h expected 1 7 0 ffffffff",
               out_valid, max_val, max_idx, min_val);
    else n_pass++;
    for (int h = 0; h < 3; h++) begin
      tick();
      n_total++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || max_val !== 32'd7 || max_idx !== 8'd0 ||
          min_val !== 32'hFFFF_FFFF)
        $display("FAIL stall_hold: got ov=%b busy=%b max=%h idx=%0d min=%h expected 1 1 7 0 ffffffff",
                 out_valid, busy, max_val, max_idx, min_val);
      else n_pass++;
    end
    release_result();
    n_total++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL stall_release: got ov=%b busy=%b expected 0 0", out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_empty();
    do_start(8'd0);
    n_total++;
    if (out_valid !== 1'b1 || empty !== 1'b1 || in_ready !== 1'b0 || max_val !== 32'h8000_0000 ||
        min_val !== 32'h7FFF_FFFF || max_idx !== 8'd0)
      $display("FAIL empty: got ov=%b empty=%b rdy=%b max=%h min=%h idx=%0d expected 1 1 0 80000000 7fffffff 0",
               out_valid, empty, in_ready, max_val, min_val, max_idx);
    else n_pass++;
    release_result();
    n_total++;
    if (busy !== 1'b0)
      $display("FAIL empty_release: got busy=%b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_ignored_start();
    do_start(8'd2);
    send_beat(32'd10);
    start = 1'b1;
    len   = 8'd0;
    tick();
    start = 1'b0;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || max_val !== 32'd10)
      $display("FAIL start_in_scan: got rdy=%b ov=%b max=%h expected 1 0 a",
               in_ready, out_valid, max_val);
    else n_pass++;
    send_beat(32'hFFFF_FFFC);
    n_total++;
    if (out_valid !== 1'b1 || max_val !== 32'd10 || min_val !== 32'hFFFF_FFFC || max_idx !== 8'd0)
      $display("FAIL ignored_result: got ov=%b max=%h min=%h idx=%0d expected 1 a fffffffc 0",
               out_valid, max_val, min_val, max_idx);
    else n_pass++;
    start     = 1'b1;
    len       = 8'd5;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    n_total++;
    if ({in_ready, busy, out_valid} !== 3'b000)
      $display("FAIL start_in_done: got %b expected 000", {in_ready, busy, out_valid});
    else n_pass++;
    tick();
    n_total++;
    if (busy !== 1'b0 || max_val !== 32'd10)
      $display("FAIL needs_fresh_start: got busy=%b max=%h expected 0 a", busy, max_val);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_start(8'd5);
    send_beat(32'd1);
    send_beat(32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++;
    if ({in_ready, busy, out_valid, empty} !== 4'b0000 || {max_val, min_val, max_idx} !== 72'h0)
      $display("FAIL reset_mid: got hs=%b max=%h min=%h idx=%0d expected 0000 0 0 0",
               {in_ready, busy, out_valid, empty}, max_val, min_val, max_idx);
    else n_pass++;
    do_start(8'd1);
    send_beat(32'd9);
    n_total++;
    if (out_valid !== 1'b1 || max_val !== 32'd9 || min_val !== 32'd9 || max_idx !== 8'd0 ||
        empty !== 1'b0)
      $display("FAIL after_reset_scan: got ov=%b max=%h min=%h idx=%0d empty=%b expected 1 9 9 0 0",
               out_valid, max_val, min_val, max_idx, empty);
    else n_pass++;
    release_result();
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset     = 1'b1;
    start     = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_all_min();
    test_stalls();
    test_empty();
    test_ignored_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
